// File: rtl/motion_frame_sequencer_pkg.sv
// Shared types and helpers for the motion frame sequencer.
package motion_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  function automatic int frame_pixels(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

endpackage

// File: rtl/motion_frame_sequencer_if.sv
// Control, memory-read, detector and motion-map signals of the frame sequencer.
interface motion_frame_sequencer_if #(
  parameter int ADDR_W = 17
);
  import motion_pkg::*;

  logic              start;
  logic              abort;
  pixel_t            threshold_cfg;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              det_enable;
  pixel_t            det_threshold;
  logic              det_motion;
  logic              map_wr_en;
  logic [ADDR_W-1:0] map_wr_addr;
  logic              map_wr_data;
  logic [ADDR_W-1:0] motion_count;

  modport master (
    input  start, abort, threshold_cfg, det_motion,
    output busy, done, mem_rd_en, mem_rd_addr, det_enable, det_threshold,
           map_wr_en, map_wr_addr, map_wr_data, motion_count
  );

  modport slave (
    output start, abort, threshold_cfg, det_motion,
    input  busy, done, mem_rd_en, mem_rd_addr, det_enable, det_threshold,
           map_wr_en, map_wr_addr, map_wr_data, motion_count
  );

endinterface

// File: rtl/motion_seq_delay_line.sv
// Valid + payload shift register of configurable depth; DEPTH=0 is a wire.
module motion_seq_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                in_valid,
  input  logic [WIDTH-1:0]                    in_data,
  output logic                                out_valid,
  output logic [WIDTH-1:0]                    out_data,
  output logic [((DEPTH > 0) ? DEPTH : 1)-1:0] stage_valid
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid   = in_valid;
      assign out_data    = in_data;
      assign stage_valid = '0;
    end else begin : g_pipe
      logic [DEPTH-1:0] vld_q;
      logic [WIDTH-1:0] dat_q [DEPTH];

      // Payload is zeroed with its valid so idle stages never carry stale addresses.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= in_valid;
          dat_q[0] <= in_valid ? in_data : '0;
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign out_valid   = vld_q[DEPTH-1];
      assign out_data    = dat_q[DEPTH-1];
      assign stage_valid = vld_q;
    end
  endgenerate

endmodule

// File: rtl/motion_frame_sequencer.sv
// Frame sequencer: walks every pixel address, aligns detector enable with read
// data and writes each motion result into the motion map.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one read per cycle, addresses 0..N-1
// DRAIN | reads finished, waiting for the last write to leave the pipeline
// DONE  | one-cycle completion pulse, then back to IDLE
module motion_frame_sequencer
  import motion_pkg::*;
#(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int ADDR_W  = 17,
  parameter int RD_LAT  = 2,
  parameter int DET_LAT = 1
) (
  input logic                      clk,
  input logic                      rst,
  motion_frame_sequencer_if.master seq
);

  localparam int                  N_PIX     = frame_pixels(IMG_W, IMG_H);
  localparam int                  TOT_LAT   = RD_LAT + DET_LAT;
  localparam int                  DET_VW    = (DET_LAT > 0) ? DET_LAT : 1;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(N_PIX - 1);
  localparam logic [TOT_LAT-1:0]  OUT_STAGE = TOT_LAT'(1) << (TOT_LAT - 1);

  seq_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   count_q;
  pixel_t              thr_q;

  logic                start_ok;
  logic                flush;
  logic                rd_fire;
  logic                pending;

  logic                rd_v, det_v;
  logic [ADDR_W-1:0]   rd_a, det_a;
  logic [RD_LAT-1:0]   rd_stage;
  logic [DET_VW-1:0]   det_stage;
  logic [TOT_LAT-1:0]  all_stage;

  assign start_ok = (state_q == IDLE) && seq.start && !seq.abort;
  assign flush    = (state_q != IDLE) && seq.abort;
  assign rd_fire  = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN: begin
        if (seq.abort)                state_d = IDLE;
        else if (addr_q == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        if (seq.abort)    state_d = IDLE;
        else if (!pending) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
      thr_q   <= '0;
    end else begin
      if (start_ok) begin
        addr_q  <= '0;
        count_q <= '0;
        thr_q   <= seq.threshold_cfg;
      end else begin
        if (rd_fire) addr_q <= addr_q + 1'b1;
        if (det_v && seq.det_motion && (count_q != '1)) count_q <= count_q + 1'b1;
      end
    end
  end

  motion_seq_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (ADDR_W)
  ) u_rd_dly (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (rd_fire),
    .in_data     (addr_q),
    .out_valid   (rd_v),
    .out_data    (rd_a),
    .stage_valid (rd_stage)
  );

  motion_seq_delay_line #(
    .DEPTH (DET_LAT),
    .WIDTH (ADDR_W)
  ) u_det_dly (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (rd_v),
    .in_data     (rd_a),
    .out_valid   (det_v),
    .out_data    (det_a),
    .stage_valid (det_stage)
  );

  generate
    if (DET_LAT > 0) begin : g_all_two
      assign all_stage = {det_stage, rd_stage};
    end else begin : g_all_rd
      assign all_stage = rd_stage;
    end
  endgenerate

  // The final stage is the write happening this cycle; anything earlier still owes a write.
  assign pending = |(all_stage & ~OUT_STAGE);

  assign seq.busy          = (state_q != IDLE);
  assign seq.done          = (state_q == DONE);
  assign seq.mem_rd_en     = rd_fire;
  assign seq.mem_rd_addr   = rd_fire ? addr_q : '0;
  assign seq.det_enable    = rd_v;
  assign seq.det_threshold = thr_q;
  assign seq.map_wr_en     = det_v;
  assign seq.map_wr_addr   = det_v ? det_a : '0;
  assign seq.map_wr_data   = det_v & seq.det_motion;
  assign seq.motion_count  = count_q;

endmodule

// File: tb/tb_motion_frame_sequencer.sv
// Directed table-driven bench for motion_frame_sequencer with a 4x2 frame.
module tb_motion_frame_sequencer;
  import motion_pkg::*;

  localparam int AW = 17;

  typedef struct {
    logic          rst, start, abort;
    logic [7:0]    thr, mask;
    logic          rd_en;
    logic [AW-1:0] rd_a;
    logic          det, wr;
    logic [AW-1:0] wr_a;
    logic          wr_d, done, busy;
    logic [AW-1:0] cnt;
    logic [7:0]    dthr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cur_mask = 8'h00;
  logic [2:0] p_v = 3'b000;
  logic [AW-1:0] p_a [3];

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  motion_frame_sequencer_if #(.ADDR_W(AW)) bus ();

  motion_frame_sequencer #(
    .IMG_W   (4),
    .IMG_H   (2),
    .ADDR_W  (AW),
    .RD_LAT  (2),
    .DET_LAT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .seq (bus.master)
  );

  // Memory plus detector model: result for a read appears three cycles later.
  always @(posedge clk) begin
    p_v    <= {p_v[1:0], bus.mem_rd_en};
    p_a[0] <= bus.mem_rd_addr;
    p_a[1] <= p_a[0];
    p_a[2] <= p_a[1];
  end
  assign bus.det_motion = p_v[2] && cur_mask[p_a[2][2:0]];

  function automatic void add(input logic r, s, a, input logic [7:0] t, m,
                              input logic re, input int ra, input logic de, we,
                              input int wa, input logic wd, dn, bz,
                              input int cn, input int dt);
    vec_t v;
    v.rst = r; v.start = s; v.abort = a; v.thr = t; v.mask = m;
    v.rd_en = re; v.rd_a = AW'(ra); v.det = de; v.wr = we; v.wr_a = AW'(wa);
    v.wr_d = wd; v.done = dn; v.busy = bz; v.cnt = AW'(cn); v.dthr = 8'(dt);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int wrs;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.threshold_cfg = 8'd0;

    // reset, then start+abort in IDLE (abort wins)
    add(1,0,0,  0,8'h00, 0,0,0,0,0,0,0,0,0, 0);
    add(0,1,1, 99,8'h00, 0,0,0,0,0,0,0,0,0, 0);
    add(0,0,0, 99,8'h00, 0,0,0,0,0,0,0,0,0, 0);
    // basic frame, motion at 2 and 5; threshold_cfg change and second start ignored
    add(0,1,0, 20,8'h24, 0,0,0,0,0,0,0,0,0, 0);
    add(0,0,0, 20,8'h24, 1,0,0,0,0,0,0,1,0,20);
    add(0,0,0, 20,8'h24, 1,1,0,0,0,0,0,1,0,20);
    add(0,0,0, 20,8'h24, 1,2,1,0,0,0,0,1,0,20);
    add(0,0,0,200,8'h24, 1,3,1,1,0,0,0,1,0,20);
    add(0,1,0,200,8'h24, 1,4,1,1,1,0,0,1,0,20);
    add(0,0,0,200,8'h24, 1,5,1,1,2,1,0,1,0,20);
    add(0,0,0,200,8'h24, 1,6,1,1,3,0,0,1,1,20);
    add(0,0,0,200,8'h24, 1,7,1,1,4,0,0,1,1,20);
    add(0,0,0,200,8'h24, 0,0,1,1,5,1,0,1,1,20);
    add(0,0,0,200,8'h24, 0,0,1,1,6,0,0,1,2,20);
    add(0,0,0,200,8'h24, 0,0,0,1,7,0,0,1,2,20);
    add(0,0,0,200,8'h24, 0,0,0,0,0,0,1,1,2,20);
    add(0,0,0,200,8'h24, 0,0,0,0,0,0,0,0,2,20);
    // abort mid-RUN at frame cycle 4, motion at address 0
    add(0,1,0, 77,8'h01, 0,0,0,0,0,0,0,0,2,20);
    add(0,0,0, 77,8'h01, 1,0,0,0,0,0,0,1,0,77);
    add(0,0,0, 77,8'h01, 1,1,0,0,0,0,0,1,0,77);
    add(0,0,0, 77,8'h01, 1,2,1,0,0,0,0,1,0,77);
    add(0,0,1, 77,8'h01, 1,3,1,1,0,1,0,1,0,77);
    for (int k = 0; k < 4; k++)
      add(0,0,0, 77,8'h01, 0,0,0,0,0,0,0,0,1,77);
    // back-to-back frames with start held, motion at 3, then reset in DRAIN
    add(0,1,0, 50,8'h08, 0,0,0,0,0,0,0,0,1,77);
    for (int f = 0; f < 2; f++) begin
      add(0,1,0,50,8'h08, 1,0,0,0,0,0,0,1,0,50);
      add(0,1,0,50,8'h08, 1,1,0,0,0,0,0,1,0,50);
      add(0,1,0,50,8'h08, 1,2,1,0,0,0,0,1,0,50);
      add(0,1,0,50,8'h08, 1,3,1,1,0,0,0,1,0,50);
      add(0,1,0,50,8'h08, 1,4,1,1,1,0,0,1,0,50);
      add(0,1,0,50,8'h08, 1,5,1,1,2,0,0,1,0,50);
      add(0,1,0,50,8'h08, 1,6,1,1,3,1,0,1,0,50);
      add(0,1,0,50,8'h08, 1,7,1,1,4,0,0,1,1,50);
      if (f == 0) begin
        add(0,1,0,50,8'h08, 0,0,1,1,5,0,0,1,1,50);
        add(0,1,0,50,8'h08, 0,0,1,1,6,0,0,1,1,50);
        add(0,1,0,50,8'h08, 0,0,0,1,7,0,0,1,1,50);
        add(0,1,0,50,8'h08, 0,0,0,0,0,0,1,1,1,50);
        add(0,1,0,50,8'h08, 0,0,0,0,0,0,0,0,1,50);
      end
    end
    add(0,1,0, 50,8'h08, 0,0,1,1,5,0,0,1,1,50);
    add(1,0,0, 50,8'h08, 0,0,1,1,6,0,0,1,1,50);
    add(0,0,0, 50,8'h08, 0,0,0,0,0,0,0,0,0, 0);
    add(0,0,0, 50,8'h08, 0,0,0,0,0,0,0,0,0, 0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      bus.start = vecs[i].start;
      bus.abort = vecs[i].abort;
      bus.threshold_cfg = vecs[i].thr;
      cur_mask = vecs[i].mask;
      #1;
      chk("mem_rd_en",     i, 32'(bus.mem_rd_en),     32'(vecs[i].rd_en));
      chk("mem_rd_addr",   i, 32'(bus.mem_rd_addr),   32'(vecs[i].rd_a));
      chk("det_enable",    i, 32'(bus.det_enable),    32'(vecs[i].det));
      chk("map_wr_en",     i, 32'(bus.map_wr_en),     32'(vecs[i].wr));
      chk("map_wr_addr",   i, 32'(bus.map_wr_addr),   32'(vecs[i].wr_a));
      chk("map_wr_data",   i, 32'(bus.map_wr_data),   32'(vecs[i].wr_d));
      chk("done",          i, 32'(bus.done),          32'(vecs[i].done));
      chk("busy",          i, 32'(bus.busy),          32'(vecs[i].busy));
      chk("motion_count",  i, 32'(bus.motion_count),  32'(vecs[i].cnt));
      chk("det_threshold", i, 32'(bus.det_threshold), 32'(vecs[i].dthr));
      tick();
    end

    // every pixel moving: done latency, write count and full motion_count
    rst = 1'b0;
    bus.abort = 1'b0;
    cur_mask = 8'hFF;
    bus.threshold_cfg = 8'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wrs = 0;
    for (cyc = 1; cyc < 50 && bus.done !== 1'b1; cyc++) begin
      if (bus.map_wr_en === 1'b1) wrs++;
      tick();
    end
    chk("done_latency",   900, 32'(cyc), 32'd12);
    chk("write_total",    901, 32'(wrs), 32'd8);
    chk("full_count",     902, 32'(bus.motion_count), 32'd8);
    chk("full_threshold", 903, 32'(bus.det_threshold), 32'd9);
    tick();
    chk("busy_after_done", 904, 32'(bus.busy), 32'd0);
    chk("count_hold",      905, 32'(bus.motion_count), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
